// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-bit flip-flop bank that behaves as SR, JK, D or T
// flip-flops (run-time mode select), with clock enable, single-event-per-cycle
// illegal SR input detection and a saturating illegal-event counter.
// Optional build macro FF_BANK_LOAD_EN adds a parallel load (load/load_val)
// that overrides enable and mode; reset still has the highest priority.
module multi_mode_ff_bank #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 err_clr,
`ifdef FF_BANK_LOAD_EN
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
`endif
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qb,
  output logic                 illegal,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [WIDTH-1:0]     q_q;
  logic [WIDTH-1:0]     q_d;
  logic                 illegal_q;
  logic                 illegal_d;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic [ERR_CNT_W-1:0] cnt_base_s;
  logic                 load_s;

`ifdef FF_BANK_LOAD_EN
  assign load_s = load;
`else
  assign load_s = 1'b0;
`endif

  // Per-bit next state by mode; enable gates everything, load overrides mode.
  always_comb begin
    q_d = q_q;
    if (load_s) begin
`ifdef FF_BANK_LOAD_EN
      q_d = load_val;
`else
      q_d = q_q;
`endif
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          MODE_SR: begin
            case ({a[i], b[i]})
              2'b10:   q_d[i] = 1'b1;
              2'b01:   q_d[i] = 1'b0;
              default: q_d[i] = q_q[i];  // 00 hold, 11 illegal -> hold
            endcase
          end
          MODE_JK: begin
            case ({a[i], b[i]})
              2'b10:   q_d[i] = 1'b1;
              2'b01:   q_d[i] = 1'b0;
              2'b11:   q_d[i] = ~q_q[i];
              default: q_d[i] = q_q[i];
            endcase
          end
          MODE_D: begin
            q_d[i] = a[i];
          end
          MODE_T: begin
            if (a[i]) begin
              q_d[i] = ~q_q[i];
            end else begin
              q_d[i] = q_q[i];
            end
          end
          default: q_d[i] = q_q[i];
        endcase
      end
    end else begin
      q_d = q_q;
    end
  end

  // One illegal event per cycle: any bit with S=R=1 while enabled in SR mode.
  always_comb begin
    illegal_d = 1'b0;
    if (en && (mode == MODE_SR) && ((a & b) != {WIDTH{1'b0}}) && !load_s) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = 1'b0;
    end
  end

  // Counter update: clear first, then count the event, saturating at max.
  always_comb begin
    cnt_base_s = err_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (err_clr) begin
      cnt_base_s = {ERR_CNT_W{1'b0}};
    end else begin
      cnt_base_s = err_cnt_q;
    end
    if (illegal_d && (cnt_base_s != CNT_MAX)) begin
      err_cnt_d = cnt_base_s + ERR_CNT_W'(1);
    end else begin
      err_cnt_d = cnt_base_s;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= {WIDTH{1'b0}};
      illegal_q <= 1'b0;
      err_cnt_q <= {ERR_CNT_W{1'b0}};
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign q       = q_q;
  assign qb      = ~q_q;
  assign illegal = illegal_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: doc/multi_mode_ff_bank.md
Name: multi_mode_ff_bank

Overview:
- Parametrised successor to the single-bit SR flip-flop: a WIDTH-bit bank of flip-flops sharing one clock.
- The whole bank runs as SR, JK, D or T flip-flops, selected at run time by `mode`.
- Adds clock enable, per-cycle detection of illegal SR input (S=R=1), and a saturating illegal-event counter with clear.
- Used as the general-purpose state-bit bank in flip-flop-level datapaths and their benches.

Parameters:
- WIDTH, 8, number of flip-flop bits in the bank.
- ERR_CNT_W, 4, width of the illegal-event counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; 0 = hold all state.
- mode  input  2  00 SR, 01 JK, 10 D, 11 T.
- a  input  WIDTH  per-bit S (SR), J (JK), D (D), T (T).
- b  input  WIDTH  per-bit R (SR), K (JK); ignored in D and T modes.
- err_clr  input  1  synchronous clear of err_cnt.
- q  output  WIDTH  flip-flop state.
- qb  output  WIDTH  always ~q (combinational from q).
- illegal  output  1  registered; high for one cycle after an edge that sampled an SR-mode illegal input.
- err_cnt  output  ERR_CNT_W  saturating count of illegal-input cycles.

Behaviour:
- Reset (rst=1 at rising clk) overrides everything:
  - q=0, so qb=all ones.
  - illegal=0, err_cnt=0.
- Latency: q reflects inputs sampled at edge N immediately after edge N (one register stage). No combinational path from a/b to q.
- en=0 (rst=0):
  - q holds.
  - illegal=0 at the next edge.
  - err_cnt holds, except that err_clr still clears it.
- en=1, per bit i, next q[i] by mode:
  - SR: a=1,b=0 gives 1; a=0,b=1 gives 0; a=0,b=0 holds; a=1,b=1 holds (illegal).
  - JK: 00 holds; 10 gives 1; 01 gives 0; 11 toggles.
  - D: q[i]=a[i].
  - T: a[i]=1 toggles, else holds.
- Illegal detection:
  - Condition: en=1 and mode=00 and (a & b) != 0.
  - illegal is set to 1 at that edge and cleared at the next edge unless the condition recurs.
  - Only one event per cycle, regardless of how many bits are illegal.
- err_cnt:
  - +1 on each edge where the illegal condition holds.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - err_clr=1 loads 0, plus 1 if the illegal condition is present in the same cycle (clear first, then count).
- Mode change takes effect at the edge where the new mode is sampled; no state is lost across a mode change.
- Reset mid-operation: the state listed above is reached at that edge regardless of en, mode or err_clr.

Optional Feature:
- Macro: FF_BANK_LOAD_EN.
- Defined:
  - Adds ports `load` (input, 1) and `load_val` (input, WIDTH).
  - load=1 sets q=load_val at the edge, independent of en and mode.
  - Priority: rst > load > en/mode.
  - load does not generate illegal events, and illegal=0 the next cycle.
- Not defined:
  - Ports absent.
  - Behaviour exactly as above.

Test Plan:
- Reset: rst=1 for 2 edges with a=8'hFF, b=0, en=1, mode=00 -> q=8'h00, qb=8'hFF, illegal=0, err_cnt=0.
- SR sequence (mode=00, en=1, WIDTH=8):
  - {a,b}=(8'h0F,8'h00) -> q=8'h0F.
  - then (8'h00,8'h03) -> q=8'h0C.
  - then (8'h00,8'h00) -> q=8'h0C.
  - then (8'h01,8'h01) -> q=8'h0C, illegal=1 for one cycle, err_cnt=1.
- JK/T toggling: from q=8'hAA:
  - mode=01, a=b=8'hFF -> q=8'h55.
  - mode=11, a=8'h0F -> q=8'h5A.
  - mode=10, a=8'h3C -> q=8'h3C.
- Enable hold: q=8'h3C, en=0, mode=00, a=b=8'hFF for 3 edges -> q=8'h3C, illegal=0, err_cnt unchanged.
- Counter saturation/clear (ERR_CNT_W=4):
  - 20 consecutive illegal SR cycles -> err_cnt=15, held at 15.
  - err_clr=1 with an illegal input in the same cycle -> err_cnt=1.
  - err_clr=1 with no illegal input -> err_cnt=0.
- With FF_BANK_LOAD_EN: q=8'h00, load=1, load_val=8'hC3, en=0 -> q=8'hC3. Same cycle with rst=1 -> q=8'h00.
